// File: rtl/e203_exu_oitf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_oitf_pkg
// Description : Shared sizing constants, entry type and tag-width helper for
//               the Outstanding Instruction Track FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package e203_exu_oitf_pkg;

  // Tag width for a given depth: log2(depth), but never narrower than 1 bit
  // so a single-entry FIFO still has a well-formed pointer.
  function automatic int e203_itag_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int E203_OITF_DEPTH  = 2;
  localparam int E203_ITAG_WIDTH  = e203_itag_width(E203_OITF_DEPTH);
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE     = 32;
  // Pointer width including the wrap flag bit.
  localparam int E203_OITF_PTR_W  = E203_ITAG_WIDTH + 1;

  // One tracked long-pipe instruction.
  typedef struct packed {
    logic                        vld;
    logic                        rdwen;
    logic                        rdfpu;
    logic [E203_RFIDX_WIDTH-1:0] rdidx;
    logic [E203_PC_SIZE-1:0]     pc;
  } oitf_entry_t;

endpackage
`default_nettype wire

// File: rtl/e203_exu_oitf_if.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_oitf_if
// Description : Dispatch / write-back side bundle of the OITF. The master is
//               dispatch plus the long-pipe retire logic; the slave is the
//               OITF itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface e203_exu_oitf_if
  import e203_exu_oitf_pkg::*;
#(
  parameter int ITAG_W  = E203_ITAG_WIDTH,
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int PC_W    = E203_PC_SIZE
);
  logic               dis_ena;
  logic               dis_ready;
  logic [ITAG_W-1:0]  dis_ptr;
  logic               ret_ena;
  logic [ITAG_W-1:0]  ret_ptr;
  logic [RFIDX_W-1:0] ret_rdidx;
  logic               ret_rdwen;
  logic               ret_rdfpu;
  logic [PC_W-1:0]    ret_pc;

  logic               disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen;
  logic               disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu;
  logic [RFIDX_W-1:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx;
  logic [PC_W-1:0]    disp_i_pc;

  logic               oitfrd_match_disprs1, oitfrd_match_disprs2;
  logic               oitfrd_match_disprs3, oitfrd_match_disprd;
  logic               oitf_empty;

  modport master (
    output dis_ena, ret_ena,
    output disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen,
    output disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu,
    output disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx,
    output disp_i_pc,
    input  dis_ready, dis_ptr, ret_ptr, ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc,
    input  oitfrd_match_disprs1, oitfrd_match_disprs2,
    input  oitfrd_match_disprs3, oitfrd_match_disprd, oitf_empty
  );

  modport slave (
    input  dis_ena, ret_ena,
    input  disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen,
    input  disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu,
    input  disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx,
    input  disp_i_pc,
    output dis_ready, dis_ptr, ret_ptr, ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc,
    output oitfrd_match_disprs1, oitfrd_match_disprs2,
    output oitfrd_match_disprs3, oitfrd_match_disprd, oitf_empty
  );
endinterface
`default_nettype wire

// File: rtl/e203_exu_oitf_ptr.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_oitf_ptr
// Description : Wrapping FIFO pointer with a wrap flag that toggles each time
//               the pointer rolls over from DEPTH-1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module e203_exu_oitf_ptr #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  output logic      [PTR_W-1:0] ptr,
  output logic                  flag
);

  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_ptr;
  logic             r_flag;

  // Advance on inc; at the last slot wrap to 0 and toggle the flag
  // (with DEPTH=1 the pointer is always at the last slot, so only the flag moves).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_flag <= 1'b0;
    end else if (inc) begin
      if (r_ptr == C_LAST) begin
        r_ptr  <= '0;
        r_flag <= ~r_flag;
      end else begin
        r_ptr  <= r_ptr + PTR_W'(1);
      end
    end
  end

  assign ptr  = r_ptr;
  assign flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/e203_exu_oitf.sv
`default_nettype none
// ============================================================================
// Module      : e203_exu_oitf
// Description : Outstanding Instruction Track FIFO. Allocates an entry per
//               dispatched long-pipe instruction, retires in order on
//               write-back and reports RAW/WAW operand hazards to dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module e203_exu_oitf
  import e203_exu_oitf_pkg::*;
#(
  parameter int DEPTH  = E203_OITF_DEPTH,      // power of two, >= 1
  parameter int ITAG_W = e203_itag_width(DEPTH)
) (
  input wire logic          clk,
  input wire logic          rst_n,
  e203_exu_oitf_if.slave    oitf
);

  logic [ITAG_W-1:0] w_alc_ptr, w_ret_ptr;
  logic              w_alc_flag, w_ret_flag;
  logic              w_full, w_empty;
  logic              w_alc, w_ret;

  // Same slot index: the wrap flags tell full (differ) from empty (equal).
  assign w_full  = (w_alc_ptr == w_ret_ptr) && (w_alc_flag != w_ret_flag);
  assign w_empty = (w_alc_ptr == w_ret_ptr) && (w_alc_flag == w_ret_flag);

  // Illegal requests (allocate while full, retire while empty) are dropped.
  assign w_alc = oitf.dis_ena & ~w_full;
  assign w_ret = oitf.ret_ena & ~w_empty;

  e203_exu_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(ITAG_W)) u_alc_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_alc),
    .ptr   (w_alc_ptr),
    .flag  (w_alc_flag)
  );

  e203_exu_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(ITAG_W)) u_ret_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_ret),
    .ptr   (w_ret_ptr),
    .flag  (w_ret_flag)
  );

  oitf_entry_t       w_entries [DEPTH];
  logic [DEPTH-1:0]  w_hit_rs1, w_hit_rs2, w_hit_rs3, w_hit_rd;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      oitf_entry_t r_entry;
      logic        w_rd_live;

      // Fill the slot on allocation, drop its valid bit on retirement. The two
      // never target the same slot in one cycle: equal pointers mean either
      // full (allocation blocked) or empty (retirement blocked).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_entry <= '0;
        end else if (w_alc && (w_alc_ptr == ITAG_W'(i))) begin
          r_entry.vld   <= 1'b1;
          r_entry.rdwen <= oitf.disp_i_rdwen;
          r_entry.rdfpu <= oitf.disp_i_rdfpu;
          r_entry.rdidx <= oitf.disp_i_rdidx;
          r_entry.pc    <= oitf.disp_i_pc;
        end else if (w_ret && (w_ret_ptr == ITAG_W'(i))) begin
          r_entry.vld   <= 1'b0;
        end
      end

      assign w_entries[i] = r_entry;
      assign w_rd_live    = r_entry.vld & r_entry.rdwen;

      // Hazard comparators see registered state only, so a same-cycle
      // allocation is invisible and a same-cycle retirement still matches.
      assign w_hit_rs1[i] = w_rd_live & (r_entry.rdidx == oitf.disp_i_rs1idx)
                                      & (r_entry.rdfpu == oitf.disp_i_rs1fpu);
      assign w_hit_rs2[i] = w_rd_live & (r_entry.rdidx == oitf.disp_i_rs2idx)
                                      & (r_entry.rdfpu == oitf.disp_i_rs2fpu);
      assign w_hit_rs3[i] = w_rd_live & (r_entry.rdidx == oitf.disp_i_rs3idx)
                                      & (r_entry.rdfpu == oitf.disp_i_rs3fpu);
      assign w_hit_rd[i]  = w_rd_live & (r_entry.rdidx == oitf.disp_i_rdidx)
                                      & (r_entry.rdfpu == oitf.disp_i_rdfpu);
    end
  endgenerate

  assign oitf.oitfrd_match_disprs1 = oitf.disp_i_rs1en & (|w_hit_rs1);
  assign oitf.oitfrd_match_disprs2 = oitf.disp_i_rs2en & (|w_hit_rs2);
  assign oitf.oitfrd_match_disprs3 = oitf.disp_i_rs3en & (|w_hit_rs3);
  assign oitf.oitfrd_match_disprd  = oitf.disp_i_rdwen & (|w_hit_rd);

  assign oitf.dis_ready  = ~w_full;
  assign oitf.dis_ptr    = w_alc_ptr;
  assign oitf.oitf_empty = w_empty;
  assign oitf.ret_ptr    = w_ret_ptr;

  // Oldest entry; storage resets to zero so these stay X-free even when empty.
  assign oitf.ret_rdidx  = w_entries[w_ret_ptr].rdidx;
  assign oitf.ret_rdwen  = w_entries[w_ret_ptr].rdwen;
  assign oitf.ret_rdfpu  = w_entries[w_ret_ptr].rdfpu;
  assign oitf.ret_pc     = w_entries[w_ret_ptr].pc;

  // Flag protocol misuse by the surrounding pipeline.
  a_no_alloc_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(oitf.dis_ena && w_full));
  a_no_retire_when_empty: assert property (
    @(posedge clk) disable iff (!rst_n) !(oitf.ret_ena && w_empty));

endmodule
`default_nettype wire
